// File: rtl/multdiv_issue_if.sv
// Handshake bundle between the pipeline-side issuer (master) and the
// multi-cycle multiply/divide unit (slave).
interface multdiv_issue_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_issue.sv
// Pipeline-side initiator for the multdiv unit: accept, pulse, stall until ready, write back.
// Optional WAIT abort after TIMEOUT cycles is enabled with `define MULTDIV_TIMEOUT_EN.
module multdiv_issue #(
  parameter int TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               op_valid,
  input  logic               op_is_div,
  input  logic [31:0]        op_a,
  input  logic [31:0]        op_b,
  input  logic [4:0]         op_rd,
  multdiv_issue_if.master    md,
  output logic               stall,
  output logic               wb_valid,
  output logic [31:0]        wb_result,
  output logic [4:0]         wb_rd,
  output logic               wb_exception
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_r;
  logic [4:0] rd_r;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] wait_cnt_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT == 0);
`endif

  // Stall must rise in the same cycle the op is presented, so it is decoded from state.
  assign stall = ~reset & (((state_r == IDLE) & op_valid) | (state_r == START) | (state_r == WAIT));

  // Issue FSM with registered ctrl pulses, operand latches and writeback capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      rd_r             <= 5'd0;
      md.ctrl_MULT     <= 1'b0;
      md.ctrl_DIV      <= 1'b0;
      md.data_operandA <= 32'd0;
      md.data_operandB <= 32'd0;
      wb_valid         <= 1'b0;
      wb_result        <= 32'd0;
      wb_rd            <= 5'd0;
      wb_exception     <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      wait_cnt_r       <= {CW{1'b0}};
`endif
    end else begin
      md.ctrl_MULT <= 1'b0;
      md.ctrl_DIV  <= 1'b0;
      wb_valid     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (op_valid) begin
            md.data_operandA <= op_a;
            md.data_operandB <= op_b;
            rd_r             <= op_rd;
            md.ctrl_MULT     <= ~op_is_div;
            md.ctrl_DIV      <= op_is_div;
            state_r          <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          // A ready seen while the start pulse is still on the wire cannot belong to this op.
`ifdef MULTDIV_TIMEOUT_EN
          wait_cnt_r <= {CW{1'b0}};
`endif
          state_r <= WAIT;
        end
        WAIT: begin
          if (md.data_resultRDY) begin
            wb_result    <= md.data_result;
            wb_exception <= md.data_exception;
            wb_rd        <= rd_r;
            wb_valid     <= 1'b1;
            state_r      <= DONE;
`ifdef MULTDIV_TIMEOUT_EN
          end else if (wait_cnt_r == CW'(TIMEOUT - 1)) begin
            wb_result    <= 32'd0;
            wb_exception <= 1'b1;
            wb_rd        <= rd_r;
            wb_valid     <= 1'b1;
            state_r      <= DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
            state_r    <= WAIT;
          end
`else
          end else begin
            state_r <= WAIT;
          end
`endif
        end
        DONE: begin
          // op_valid here is the instruction just completed, so it is not re-accepted.
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed self-checking bench for multdiv_issue; the bench itself plays the multdiv unit.
module tb_multdiv_issue;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int TMO = 8;
  localparam int D1  = 8;
`else
  localparam int TMO = 64;
  localparam int D1  = 17;
`endif

  logic        clock;
  logic        reset;
  logic        op_valid;
  logic        op_is_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  op_rd;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_exception;

  int checks   = 0;
  int failures = 0;
  int mult_cnt = 0;
  int div_cnt  = 0;
  int both_cnt = 0;

  multdiv_issue_if md ();

  multdiv_issue #(.TIMEOUT(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_is_div    (op_is_div),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_rd        (op_rd),
    .md           (md),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_result    (wb_result),
    .wb_rd        (wb_rd),
    .wb_exception (wb_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Ctrl pulse tally, sampled mid-cycle.
  always @(negedge clock) begin
    if (md.ctrl_MULT) mult_cnt <= mult_cnt + 1;
    if (md.ctrl_DIV) div_cnt <= div_cnt + 1;
    if (md.ctrl_MULT && md.ctrl_DIV) both_cnt <= both_cnt + 1;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk1({tag, "_ctrl_mult"}, md.ctrl_MULT, 1'b0);
    chk1({tag, "_ctrl_div"}, md.ctrl_DIV, 1'b0);
    chk1({tag, "_stall"}, stall, 1'b0);
    chk1({tag, "_wb_valid"}, wb_valid, 1'b0);
    chk1({tag, "_wb_exc"}, wb_exception, 1'b0);
    chk32({tag, "_wb_result"}, wb_result, 32'd0);
    chk32({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    chk32({tag, "_opa"}, md.data_operandA, 32'd0);
    chk32({tag, "_opb"}, md.data_operandB, 32'd0);
  endtask

  // One full op; the bench raises RDY 'delay' cycles after the ctrl pulse.
  task automatic do_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int delay, input logic junk,
                       input logic [31:0] res, input logic exc);
    int m0;
    int d0;
    int stalls;
    m0 = mult_cnt;
    d0 = div_cnt;
    stalls = 0;
    op_valid = 1'b1; op_is_div = is_div; op_a = a; op_b = b; op_rd = rd;
    #1;
    chk1("accept_stall", stall, 1'b1);
    if (stall) stalls++;
    step();
    chk1("start_ctrl_mult", md.ctrl_MULT, ~is_div);
    chk1("start_ctrl_div", md.ctrl_DIV, is_div);
    chk32("start_opa", md.data_operandA, a);
    chk32("start_opb", md.data_operandB, b);
    if (stall) stalls++;
    if (junk) begin
      md.data_resultRDY = 1'b1; md.data_result = 32'hDEAD_BEEF; md.data_exception = 1'b0;
    end
    for (int i = 2; i <= delay; i++) begin
      step();
      md.data_resultRDY = 1'b0;
      chk1("wait_no_wb", wb_valid, 1'b0);
      if (stall) stalls++;
    end
    step();
    md.data_resultRDY = 1'b1; md.data_result = res; md.data_exception = exc;
    chk1("rdy_cycle_no_wb", wb_valid, 1'b0);
    if (stall) stalls++;
    step();
    md.data_resultRDY = 1'b0; md.data_result = 32'h0BAD_0BAD; md.data_exception = ~exc;
    chk1("done_wb_valid", wb_valid, 1'b1);
    chk1("done_stall", stall, 1'b0);
    chk32("done_wb_result", wb_result, res);
    chk32("done_wb_rd", {27'd0, wb_rd}, {27'd0, rd});
    chk1("done_wb_exc", wb_exception, exc);
    chk32("stall_cycles", stalls, delay + 2);
    op_valid = 1'b0;
    step();
    chk1("idle_wb_valid_low", wb_valid, 1'b0);
    chk1("idle_stall_low", stall, 1'b0);
    chk32("idle_wb_result_held", wb_result, res);
    chk32("mult_pulses", mult_cnt - m0, is_div ? 32'd0 : 32'd1);
    chk32("div_pulses", div_cnt - d0, is_div ? 32'd1 : 32'd0);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_is_div = 1'b0;
    op_a = 32'd0; op_b = 32'd0; op_rd = 5'd0;
    md.data_resultRDY = 1'b0; md.data_result = 32'd0; md.data_exception = 1'b0;
    step();
    step();
    chk_reset_values("reset");
    reset = 1'b0;
    step();

    // MULT 7*6 -> 42
    do_op(1'b0, 32'd7, 32'd6, 5'd5, D1, 1'b0, 32'd42, 1'b0);

    // Spurious RDY in IDLE
    md.data_resultRDY = 1'b1; md.data_result = 32'h55; md.data_exception = 1'b1;
    #1;
    chk1("spur_idle_stall", stall, 1'b0);
    step();
    md.data_resultRDY = 1'b0;
    chk1("spur_idle_wb_valid", wb_valid, 1'b0);
    chk32("spur_idle_wb_result", wb_result, 32'd42);
    chk1("spur_idle_wb_exc", wb_exception, 1'b0);
    chk32("spur_idle_opa", md.data_operandA, 32'd7);
    chk1("spur_idle_ctrl", md.ctrl_MULT, 1'b0);
    step();

    // DIV 100/0 with exception, plus a spurious RDY during START
    do_op(1'b1, 32'd100, 32'd0, 5'd3, 4, 1'b1, 32'd0, 1'b1);

    // Reset while waiting on a DIV
    op_valid = 1'b1; op_is_div = 1'b1; op_a = 32'd50; op_b = 32'd5; op_rd = 5'd9;
    step();
    step();
    step();
    chk1("pre_reset_stall", stall, 1'b1);
    reset = 1'b1;
    #1;
    chk_reset_values("midop_reset");
    op_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    md.data_resultRDY = 1'b1; md.data_result = 32'd10; md.data_exception = 1'b0;
    step();
    md.data_resultRDY = 1'b0;
    chk1("late_rdy_wb_valid", wb_valid, 1'b0);
    chk32("late_rdy_wb_result", wb_result, 32'd0);
    chk1("late_rdy_stall", stall, 1'b0);
    do_op(1'b0, 32'd3, 32'd4, 5'd2, 3, 1'b0, 32'd12, 1'b0);

    // Back-to-back MULT 2*3 then DIV 9/3
    do_op(1'b0, 32'd2, 32'd3, 5'd1, 2, 1'b0, 32'd6, 1'b0);
    do_op(1'b1, 32'd9, 32'd3, 5'd4, 2, 1'b0, 32'd3, 1'b0);

    // No RDY at all
    op_valid = 1'b1; op_is_div = 1'b0; op_a = 32'd1; op_b = 32'd1; op_rd = 5'd6;
    step();
`ifdef MULTDIV_TIMEOUT_EN
    for (int i = 2; i <= 9; i++) begin
      step();
      chk1("tmo_wait_stall", stall, 1'b1);
      chk1("tmo_wait_no_wb", wb_valid, 1'b0);
    end
    step();
    chk1("tmo_wb_valid", wb_valid, 1'b1);
    chk1("tmo_wb_exc", wb_exception, 1'b1);
    chk32("tmo_wb_result", wb_result, 32'd0);
    chk32("tmo_wb_rd", {27'd0, wb_rd}, 32'd6);
    chk1("tmo_stall", stall, 1'b0);
    op_valid = 1'b0;
    step();
    chk1("tmo_idle_wb_valid", wb_valid, 1'b0);
`else
    for (int i = 2; i <= 41; i++) begin
      step();
      chk1("hang_wait_stall", stall, 1'b1);
      chk1("hang_no_wb", wb_valid, 1'b0);
    end
    reset = 1'b1;
    op_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk1("hang_recover_stall", stall, 1'b0);
`endif

    chk32("never_both_ctrl", both_cnt, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
